mem_responder: RTL

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_resp_pkg.sv | 20 ++
 rtl/mem_resp_ram.sv | 36 +++
 rtl/mem_responder.sv | 136 +++++++++++++
 3 files changed

// File: rtl/mem_resp_pkg.sv
// rtl/mem_resp_pkg.sv - shared FSM states, op encoding and default parameters for mem_responder
package mem_resp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    typedef enum logic {
        OP_READ,
        OP_WRITE
    } op_t;

    localparam int DEF_DATA_WIDTH  = 32;
    localparam int DEF_ADDR_WIDTH  = 16;
    localparam int DEF_DEPTH_WORDS = 1024;
    localparam int DEF_LATENCY     = 2;

endpackage

// File: rtl/mem_resp_ram.sv
// rtl/mem_resp_ram.sv - single-port synchronous storage with registered, holdable read data
module mem_resp_ram #(
    parameter int DATA_WIDTH  = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we,
    input  logic                  re,
    input  logic                  clr,
    input  logic [IDX_W-1:0]      addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

    // Array contents survive reset; only the read register is cleared.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata <= '0;
        end else if (clr) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - fixed-latency memory responder FSM; address-error port enabled by MEM_RESP_ERR_EN
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int DEPTH_WORDS = DEF_DEPTH_WORDS,
    parameter int LATENCY     = DEF_LATENCY
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic [ADDR_WIDTH-1:0] addr_in,
    input  logic                  read_enable,
    input  logic                  write_enable,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  ready,
    output logic                  busy
`ifdef MEM_RESP_ERR_EN
    ,
    output logic                  err
`endif
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    state_t                state;
    op_t                   op_q;
    op_t                   op_sel;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] addr_sel;
    logic [DATA_WIDTH-1:0] data_q;
    logic [3:0]            cnt;
    logic                  err_q;
    logic                  accept;
    logic                  to_resp;
    logic                  addr_bad;
    logic                  ram_we;
    logic                  ram_re;
    logic                  ram_clr;

    // In IDLE the live inputs steer the RAM so LATENCY=1 reads are ready on time.
    always_comb begin
        op_sel   = op_q;
        addr_sel = addr_q;
        if (state == IDLE) begin
            op_sel   = write_enable ? OP_WRITE : OP_READ;
            addr_sel = addr_in;
        end
    end

    assign accept  = (state == IDLE) && (read_enable || write_enable);
    assign to_resp = (accept && (LATENCY == 1)) || ((state == WAIT) && (cnt <= 4'd1));

`ifdef MEM_RESP_ERR_EN
    assign addr_bad = (addr_sel >> IDX_W) != '0;
    assign err      = err_q;
`else
    logic unused_addr_hi;
    assign addr_bad       = 1'b0;
    assign unused_addr_hi = ^(addr_sel >> IDX_W);
`endif

    assign ram_we  = (state == RESP) && (op_q == OP_WRITE) && !err_q;
    assign ram_re  = to_resp && (op_sel == OP_READ) && !addr_bad;
    assign ram_clr = to_resp && (op_sel == OP_READ) && addr_bad;

    mem_resp_ram #(
        .DATA_WIDTH  (DATA_WIDTH),
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (ram_we),
        .re    (ram_re),
        .clr   (ram_clr),
        .addr  (addr_sel[IDX_W-1:0]),
        .wdata (data_q),
        .rdata (data_out)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            op_q   <= OP_READ;
            addr_q <= '0;
            data_q <= '0;
            cnt    <= '0;
            ready  <= 1'b0;
            busy   <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            ready <= 1'b0;
            err_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        addr_q <= addr_in;
                        data_q <= data_in;
                        op_q   <= op_sel;
                        busy   <= 1'b1;
                        if (LATENCY == 1) begin
                            state <= RESP;
                            ready <= 1'b1;
                            err_q <= addr_bad;
                            cnt   <= '0;
                        end else begin
                            state <= WAIT;
                            cnt   <= 4'(LATENCY - 1);
                        end
                    end
                end
                WAIT: begin
                    if (cnt <= 4'd1) begin
                        state <= RESP;
                        ready <= 1'b1;
                        err_q <= addr_bad;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
